// File: rtl/burst_window_mem.sv
// burst_window_mem: multi-lane scratch memory with a command front end.
// Handles single-word writes and multi-beat burst writes/reads of LANES
// consecutive words per beat. Lanes whose address is past the end of memory
// are masked and flagged.

// Per-lane address generation and range check for one beat.
module burst_window_lane #(
  parameter int XW    = 30,
  parameter int DEPTH = 1201,
  parameter int LANE  = 0
) (
  input  logic [XW-1:0] base,
  output logic [XW-1:0] addr,
  output logic          inr
);
  // Wide arithmetic means an address past the end can never wrap back into range.
  assign addr = base + XW'(LANE);
  assign inr  = addr < XW'(DEPTH);
endmodule

module burst_window_mem #(
  parameter int DW    = 8,
  parameter int LANES = 20,
  parameter int DEPTH = 1201,
  parameter int AW    = 16,
  parameter int LENW  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [AW-1:0]         cmd_addr,
  input  logic [LENW-1:0]       cmd_len,
  input  logic [LANES*DW-1:0]   wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [LANES*DW-1:0]   rd_data,
  output logic                  rd_valid,
  output logic [LANES-1:0]      rd_oob,
  output logic                  done,
  output logic                  err
);
  localparam int XW = AW + LENW + 6;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] OP_WR1 = 2'b00;
  localparam logic [1:0] OP_BWR = 2'b01;
  localparam logic [1:0] OP_BRD = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  typedef enum logic [1:0] {IDLE, WRITE, READ} st_t;

  st_t                        st, st_nx;
  logic [XW-1:0]              ptr;
  logic [LENW-1:0]            cnt;
  logic                       err_acc;
  logic [LANES-1:0][XW-1:0]   ladr;
  logic [LANES-1:0]           linr;
  logic [LANES-1:0][DW-1:0]   wlane;
  logic [LANES-1:0][DW-1:0]   rq;
  logic [LANES-1:0]           wen;
  logic [LANES-1:0][IW-1:0]   widx;
  logic [LANES-1:0][DW-1:0]   wdat;
  logic [DW-1:0]              mem [DEPTH];

  logic          accept, wbeat, last, beat_err, cinr;
  logic [XW-1:0] caddr;

  assign wlane    = wr_data;
  assign rd_data  = rq;
  assign accept   = cmd_valid & cmd_ready;
  assign caddr    = XW'(cmd_addr);
  assign cinr     = caddr < XW'(DEPTH);
  assign wbeat    = (st == WRITE) & wr_valid;
  assign last     = cnt == LENW'(1);
  assign beat_err = ~&linr;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    burst_window_lane #(.XW(XW), .DEPTH(DEPTH), .LANE(g)) u_lane (
      .base (ptr),
      .addr (ladr[g]),
      .inr  (linr[g])
    );
  end

  // Write-port steering: burst beats use every lane, a single write borrows lane 0.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      wen[i]  = reset & wbeat & linr[i];
      widx[i] = ladr[i][IW-1:0];
      wdat[i] = wlane[i];
    end
    if (reset && accept && cmd_op == OP_WR1 && cinr) begin
      wen[0]  = 1'b1;
      widx[0] = caddr[IW-1:0];
      wdat[0] = wlane[0];
    end
  end

  // Storage array; never reset so contents survive an aborted burst.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (wen[i]) mem[widx[i]] <= wdat[i];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) st <= IDLE;
    else        st <= st_nx;
  end

  // Next-state logic.
  always_comb begin
    st_nx = st;
    case (st)
      IDLE:  if (accept) begin
               if (cmd_op == OP_BWR)      st_nx = WRITE;
               else if (cmd_op == OP_BRD) st_nx = READ;
             end
      WRITE: if (wr_valid && last) st_nx = IDLE;
      READ:  if (last) st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    cmd_ready = (st == IDLE);
    wr_ready  = (st == WRITE);
  end

  // Pointer/count, error accumulation, registered read beat and completion.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr      <= '0;
      cnt      <= '0;
      err_acc  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rd_valid <= 1'b0;
      rq       <= '0;
      rd_oob   <= '0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      rd_valid <= 1'b0;
      rq       <= '0;
      rd_oob   <= '0;
      case (st)
        IDLE: if (accept) begin
          case (cmd_op)
            OP_WR1: begin done <= 1'b1; err <= ~cinr; end
            OP_NOP: done <= 1'b1;
            default: begin
              ptr     <= caddr;
              cnt     <= (cmd_len == '0) ? LENW'(1) : cmd_len;
              err_acc <= 1'b0;
            end
          endcase
        end
        WRITE: if (wr_valid) begin
          ptr     <= ptr + XW'(LANES);
          cnt     <= cnt - LENW'(1);
          err_acc <= err_acc | beat_err;
          if (last) begin done <= 1'b1; err <= err_acc | beat_err; end
        end
        READ: begin
          rd_valid <= 1'b1;
          for (int i = 0; i < LANES; i++)
            rq[i] <= linr[i] ? mem[ladr[i][IW-1:0]] : '0;
          rd_oob  <= ~linr;
          ptr     <= ptr + XW'(LANES);
          cnt     <= cnt - LENW'(1);
          err_acc <= err_acc | beat_err;
          if (last) begin done <= 1'b1; err <= err_acc | beat_err; end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_burst_window_mem.sv
// Directed bench for burst_window_mem with hand-computed expectations.
module tb_burst_window_mem;
  localparam int DW = 8, LANES = 20, DEPTH = 1201, AW = 16, LENW = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                cmd_valid, cmd_ready;
  logic [1:0]          cmd_op;
  logic [AW-1:0]       cmd_addr;
  logic [LENW-1:0]     cmd_len;
  logic [LANES*DW-1:0] wr_data;
  logic                wr_valid, wr_ready;
  logic [LANES*DW-1:0] rd_data;
  logic                rd_valid;
  logic [LANES-1:0]    rd_oob;
  logic                done, err;

  int checks = 0, errors = 0;
  logic [LANES*DW-1:0] rbeat [8];
  logic [LANES-1:0]    roob  [8];

  burst_window_mem #(.DW(DW), .LANES(LANES), .DEPTH(DEPTH), .AW(AW), .LENW(LENW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_oob(rd_oob), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; outputs then show the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input int addr, input int len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = AW'(addr);
    cmd_len   = LENW'(len);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic single_wr(input int addr, input logic [DW-1:0] d, input logic exp_err);
    wr_data = '0;
    wr_data[DW-1:0] = d;
    issue(2'b00, addr, 0);
    chk("wr1_done", 64'(done), 64'd1);
    chk("wr1_err", 64'(err), 64'(exp_err));
  endtask

  // Burst read: beat k must appear in cycle T+2+k, done/err with the last beat.
  task automatic rd_burst(input int addr, input int len, input logic exp_err);
    int n;
    n = (len == 0) ? 1 : len;
    issue(2'b10, addr, len);
    chk("rd_lat", 64'(rd_valid), 64'd0);
    for (int k = 0; k < n; k++) begin
      tick();
      chk("rd_valid", 64'(rd_valid), 64'd1);
      chk("rd_done", 64'(done), 64'(k == n - 1));
      rbeat[k] = rd_data;
      roob[k]  = rd_oob;
    end
    chk("rd_err", 64'(err), 64'(exp_err));
    chk("rd_cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b11; cmd_addr = '0;
    cmd_len = '0; wr_data = '0; wr_valid = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(|rd_data), 64'd0);
    chk("rst_rd_oob", 64'(rd_oob), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    reset = 1'b1;
    tick();

    // Single write then readback
    single_wr(1000, 8'hA5, 1'b0);
    rd_burst(1000, 1, 1'b0);
    chk("rd1000_lane0", 64'(rbeat[0][DW-1:0]), 64'hA5);

    // No-op completes without error; len 0 behaves as one beat
    issue(2'b11, 0, 0);
    chk("nop_done", 64'(done), 64'd1);
    chk("nop_err", 64'(err), 64'd0);
    rd_burst(1000, 0, 1'b0);
    chk("len0_lane0", 64'(rbeat[0][DW-1:0]), 64'hA5);
    tick();
    chk("len0_no_more", 64'(rd_valid), 64'd0);

    // Burst write 3 beats with a 2-cycle gap before beat 1
    issue(2'b01, 0, 3);
    chk("bw_wr_ready", 64'(wr_ready), 64'd1);
    chk("bw_busy", 64'(cmd_ready), 64'd0);
    for (int b = 0; b < 3; b++) begin
      if (b == 1) begin
        wr_valid = 1'b0;
        tick(); tick();
        chk("bw_stall_done", 64'(done), 64'd0);
        chk("bw_stall_ready", 64'(wr_ready), 64'd1);
      end
      for (int i = 0; i < LANES; i++) wr_data[i*DW +: DW] = DW'(20 * b + i);
      wr_valid = 1'b1;
      tick();
      if (b < 2) chk("bw_mid_done", 64'(done), 64'd0);
    end
    wr_valid = 1'b0;
    chk("bw_done", 64'(done), 64'd1);
    chk("bw_err", 64'(err), 64'd0);
    chk("bw_cmd_ready", 64'(cmd_ready), 64'd1);

    // wr_valid in IDLE must not touch memory
    for (int i = 0; i < LANES; i++) wr_data[i*DW +: DW] = 8'hEE;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;

    rd_burst(0, 3, 1'b0);
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < LANES; i++)
        chk($sformatf("bw_rd_b%0d_l%0d", b, i), 64'(rbeat[b][i*DW +: DW]), 64'(20 * b + i));

    // Fill 1190..1200 back-to-back, then read straddling the end
    for (int a = 1190; a <= 1200; a++) single_wr(a, DW'((a - 1190) * 7 + 3), 1'b0);
    rd_burst(1190, 1, 1'b1);
    for (int i = 0; i < LANES; i++)
      chk($sformatf("edge_l%0d", i), 64'(rbeat[0][i*DW +: DW]),
          (i <= 10) ? 64'(i * 7 + 3) : 64'd0);
    chk("edge_oob", 64'(roob[0]), 64'hFF800);

    // Out-of-range single write is dropped and flagged
    single_wr(1201, 8'h99, 1'b1);
    rd_burst(1200, 1, 1'b1);
    chk("oob_wr_keep", 64'(rbeat[0][DW-1:0]), 64'd73);
    chk("oob_wr_oob", 64'(roob[0]), 64'hFFFFE);

    // Reset during beat 1 of a 4-beat read aborts it
    issue(2'b10, 0, 4);
    tick();
    chk("abort_beat0", 64'(rd_valid), 64'd1);
    reset = 1'b0;
    tick();
    chk("abort_rd_valid", 64'(rd_valid), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    reset = 1'b1;
    tick();
    chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("abort_quiet", 64'(rd_valid | done), 64'd0);
    single_wr(5, 8'h11, 1'b0);
    rd_burst(0, 1, 1'b0);
    chk("post_rst_wr", 64'(rbeat[0][5*DW +: DW]), 64'h11);
    chk("post_rst_keep", 64'(rbeat[0][4*DW +: DW]), 64'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
